// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared MEM-stage definitions: size codes, DM states, byte-lane enables
// Purpose : size encodings for mem_op[1:0], data-memory FSM state type and the
//           lane-enable helper used by the data memory and the store aligner.
// Ports   : none (package).
package mem_pkg;

  // mem_op[1:0] size codes; 2'b11 is reserved and behaves as a word access
  localparam logic [1:0] MEM_W = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_B = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dm_state_t;

  // Little-endian lane enables: lane k = bits [8k+7:8k]
  function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] a);
    case (size)
      MEM_H:   be_from = a[1] ? 4'b1100 : 4'b0011;
      MEM_B:   be_from = 4'b0001 << a;
      default: be_from = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - combinational load lane select with sign/zero extension
// Purpose : picks the addressed byte/half out of a stored word and extends it.
// Ports   : word in  32  stored word
//           size in  2   mem_op[1:0] size code
//           uns  in  1   1 = zero-extend, 0 = sign-extend
//           lane in  2   addr[1:0]
//           data out 32  extended load data
module dm_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   data = {{24{~uns & byte_v[7]}}, byte_v};
      MEM_H:   data = {{16{~uns & half_v[15]}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dm_be_clear.sv
// rtl/dm_be_clear.sv - byte-enabled data memory with bounded-rate clear FSM
// Purpose : MEM-stage data memory; combinational read, synchronous lane-masked
//           write, misalignment detection, and a clear sequence that zeroes
//           CLR_WORDS words per cycle after reset.
// Ports   : clk in 1, reset in 1 (sync, active-high), we in 1, mem_op in 3,
//           addr in 32, wd in 32, pc in 32 (log only), rd out 32,
//           misalign out 1, busy out 1
// Config  : DM_WRITE_LOG_EN - print one line per accepted store with the
//           full post-write word.
module dm_be_clear
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int CLR_WORDS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic [31:0] rd,
  output logic        misalign,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - CLR_WORDS);
  localparam logic [AW-1:0] PTR_STEP = AW'(CLR_WORDS);

  dm_state_t     state, state_nxt;
  logic [AW-1:0] clr_ptr, clr_ptr_nxt;
  logic          clr_en;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    size;
  logic          raw_mis;
  logic          store_ok;
  logic [3:0]    be;
  logic [31:0]   wd_al;
  logic [31:0]   cur;
  logic [31:0]   load_data;

  assign idx  = addr[AW+1:2];
  assign size = mem_op[1:0];
  assign cur  = mem[idx];

  // Reserved size 2'b11 falls into the word case
  always_comb begin
    raw_mis = 1'b0;
    if (size == MEM_H)
      raw_mis = addr[0];
    else if (size != MEM_B)
      raw_mis = (addr[1:0] != 2'b00);
  end

  // Reset counts as busy so the core stalls from the very first cycle
  assign busy     = reset || (state == ST_CLEAR);
  assign misalign = raw_mis && !busy;
  assign store_ok = we && !busy && !raw_mis;
  assign be       = be_from(size, addr[1:0]);

  // Replicate right-aligned store data onto every lane; be picks the lanes
  always_comb begin
    case (size)
      MEM_B:   wd_al = {4{wd[7:0]}};
      MEM_H:   wd_al = {2{wd[15:0]}};
      default: wd_al = wd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_en      = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_en      = !reset;
        clr_ptr_nxt = clr_ptr + PTR_STEP;
        if (clr_ptr == LAST_PTR)
          state_nxt = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      for (int k = 0; k < CLR_WORDS; k++)
        mem[clr_ptr + AW'(k)] <= '0;
    end else if (store_ok) begin
      for (int k = 0; k < 4; k++)
        if (be[k])
          mem[idx][8*k +: 8] <= wd_al[8*k +: 8];
    end
  end

  dm_load_ext u_load_ext (
    .word (cur),
    .size (size),
    .uns  (mem_op[2]),
    .lane (addr[1:0]),
    .data (load_data)
  );

  assign rd = (busy || raw_mis) ? 32'h0 : load_data;

`ifdef DM_WRITE_LOG_EN
  logic [31:0] merged_word;

  always_comb begin
    merged_word = cur;
    for (int k = 0; k < 4; k++)
      if (be[k])
        merged_word[8*k +: 8] = wd_al[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (store_ok)
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_word);
  end
`else
  logic unused_log;
  assign unused_log = ^{pc, addr[31:AW+2]};
`endif

endmodule

// File: tb/tb_dm_be_clear.sv
// tb/tb_dm_be_clear.sv - self-checking bench for dm_be_clear
module tb_dm_be_clear;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [31:0] rd;
  logic        misalign;
  logic        busy;

  always #5 clk = ~clk;

  dm_be_clear #(.DEPTH(16), .CLR_WORDS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .mem_op   (mem_op),
    .addr     (addr),
    .wd       (wd),
    .pc       (pc),
    .rd       (rd),
    .misalign (misalign),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [16];

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check(nm, n, 4);
  endtask

  task automatic check_all_zero(input string nm);
    we     = 1'b0;
    mem_op = 3'b000;
    for (int w = 0; w < 16; w++) begin
      addr = w * 4;
      #1;
      check($sformatf("%s_w%0d", nm, w), rd, 32'h0);
    end
  endtask

  // Reference: expected load result and misalign flag from the spec rules
  function automatic void model_read(input logic [2:0] op, input logic [31:0] a,
                                     output logic [31:0] r, output logic m);
    logic [31:0] w;
    int          v;
    w = model[a[5:2]];
    if (op[1:0] == 2'd1)      m = a[0];
    else if (op[1:0] == 2'd2) m = 1'b0;
    else                      m = (a[1:0] != 2'd0);
    if (m) begin
      r = 32'h0;
    end else if (op[1:0] == 2'd2) begin
      v = int'((w >> (8 * a[1:0])) & 32'hFF);
      if (!op[2] && v >= 128) v = v - 256;
      r = 32'(v);
    end else if (op[1:0] == 2'd1) begin
      v = int'((w >> (16 * a[1])) & 32'hFFFF);
      if (!op[2] && v >= 32768) v = v - 65536;
      r = 32'(v);
    end else begin
      r = w;
    end
  endfunction

  function automatic void model_write(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] d);
    logic [31:0] w;
    logic [31:0] mask;
    int          sh;
    w = model[a[5:2]];
    if (op[1:0] == 2'd2) begin
      sh   = 8 * a[1:0];
      mask = 32'hFF << sh;
      w    = (w & ~mask) | ((d & 32'hFF) << sh);
    end else if (op[1:0] == 2'd1) begin
      sh   = 16 * a[1];
      mask = 32'hFFFF << sh;
      w    = (w & ~mask) | ((d & 32'hFFFF) << sh);
    end else begin
      w = d;
    end
    model[a[5:2]] = w;
  endfunction

  task automatic rand_phase(input string nm, input int n);
    logic [31:0] er;
    logic        em;
    for (int i = 0; i < n; i++) begin
      we     = 1'($urandom_range(0, 1));
      mem_op = 3'($urandom_range(0, 7));
      addr   = $urandom;
      wd     = $urandom;
      #2;
      model_read(mem_op, addr, er, em);
      check($sformatf("%s%0d_rd", nm, i), rd, er);
      check($sformatf("%s%0d_mis", nm, i), {31'h0, misalign}, {31'h0, em});
      if (we && !em) model_write(mem_op, addr, wd);
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    //                 we    op      addr   wd            rd            mis
    vecs[0]  = '{1'b1, 3'b000, 32'h8, 32'h11223344, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 3'b010, 32'h9, 32'h000000AA, 32'h00000033, 1'b0};
    vecs[2]  = '{1'b0, 3'b000, 32'h8, 32'h0,        32'h1122AA44, 1'b0};
    vecs[3]  = '{1'b0, 3'b010, 32'h9, 32'h0,        32'hFFFFFFAA, 1'b0};
    vecs[4]  = '{1'b0, 3'b110, 32'h9, 32'h0,        32'h000000AA, 1'b0};
    vecs[5]  = '{1'b1, 3'b001, 32'hA, 32'h00008001, 32'h00001122, 1'b0};
    vecs[6]  = '{1'b0, 3'b001, 32'hA, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b0, 3'b101, 32'hA, 32'h0,        32'h00008001, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 32'h8, 32'h0,        32'h8001AA44, 1'b0};
    vecs[9]  = '{1'b1, 3'b000, 32'h6, 32'hDEADBEEF, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 3'b000, 32'h4, 32'h0,        32'h00000000, 1'b0};
    vecs[11] = '{1'b0, 3'b001, 32'h3, 32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{1'b0, 3'b011, 32'h8, 32'h0,        32'h8001AA44, 1'b0};
    vecs[13] = '{1'b0, 3'b011, 32'h9, 32'h0,        32'h00000000, 1'b1};

    reset  = 1'b1;
    we     = 1'b0;
    mem_op = 3'b000;
    addr   = 32'h8;
    wd     = 32'h0;
    pc     = 32'h3000;

    tick();
    check("reset_busy", {31'h0, busy}, 32'h1);
    check("reset_rd", rd, 32'h0);
    check("reset_mis", {31'h0, misalign}, 32'h0);
    reset = 1'b0;
    #1;
    count_busy("busy_cycles");
    check_all_zero("clr");

    for (int i = 0; i < 14; i++) begin
      we     = vecs[i].we;
      mem_op = vecs[i].op;
      addr   = vecs[i].addr;
      wd     = vecs[i].wd;
      #2;
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_mis", i), {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
      tick();
    end
    we = 1'b0;

    for (int w = 0; w < 16; w++) model[w] = 32'h0;
    model[2] = 32'h8001AA44;
    rand_phase("rndA", 150);

    // Reset again, then re-assert in the second clear cycle with stores pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("restart_busy1", {31'h0, busy}, 32'h1);
    tick();
    reset  = 1'b1;
    we     = 1'b1;
    mem_op = 3'b000;
    addr   = 32'h0;
    wd     = 32'hFFFFFFFF;
    tick();
    reset = 1'b0;
    #1;
    count_busy("busy_after_restart");
    we = 1'b0;
    check_all_zero("restart");

    for (int w = 0; w < 16; w++) model[w] = 32'h0;
    rand_phase("rndB", 150);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
